dds_sweep_ctrl: RTL and testbench

Frequency-sweep scheduler for the DDS core. It sits between the key/config logic and the dds phase accumulator and sequences the DDS frequency tuning word (FTW). The ramp runs from a start FTW to a stop FTW in fixed steps, and each FTW is held for a programmable dwell. It supports single-shot, sawtooth-repeat and triangle modes, with a start/abort handshake and a phase-clear pulse to the accumulator.

---
 rtl/dds_sweep_ctrl.sv | 127 ++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: sequences a DDS tuning word through single, sawtooth or triangle ramps with dwell.
module dds_sweep_ctrl #(
  parameter int FTW_W   = 32,
  parameter int DWELL_W = 24
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [FTW_W-1:0]   cfg_start_ftw,
  input  logic [FTW_W-1:0]   cfg_stop_ftw,
  input  logic [FTW_W-1:0]   cfg_step_ftw,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [1:0]         cfg_mode,
  input  logic               start,
  input  logic               abort,
  output logic [FTW_W-1:0]   ftw_out,
  output logic               ftw_vld,
  output logic               phase_clr,
  output logic               busy,
  output logic               done
);
  typedef enum logic {IDLE, DWELL} state_t;
  state_t state, state_n;
  logic dir, dir_n;
  logic [DWELL_W-1:0] cnt, cnt_n, dwell_s, dwell_n, dwell_m1;
  logic [FTW_W-1:0] start_s, start_n, stop_s, stop_n, step_s, step_n, ftw_n, up_c, dn_c;
  logic [1:0] mode_s, mode_n;
  logic vld_n, pclr_n, busy_n, done_n;
  logic [FTW_W:0] up_sum, dn_dif;
  // One extra bit keeps the clamp decisions exact at full scale and below zero.
  always_comb begin
    dwell_m1 = (dwell_s == '0) ? '0 : dwell_s - 1'b1;
    up_sum   = {1'b0, ftw_out} + {1'b0, step_s};
    dn_dif   = {1'b0, ftw_out} - {1'b0, step_s};
    up_c     = (up_sum > {1'b0, stop_s}) ? stop_s : up_sum[FTW_W-1:0];
    dn_c     = (dn_dif[FTW_W] || dn_dif[FTW_W-1:0] < start_s) ? start_s : dn_dif[FTW_W-1:0];
  end
  always_comb begin
    state_n = state;
    dir_n   = dir;
    cnt_n   = cnt;
    ftw_n   = ftw_out;
    busy_n  = busy;
    vld_n   = 1'b0;
    pclr_n  = 1'b0;
    done_n  = 1'b0;
    start_n = start_s;
    stop_n  = stop_s;
    step_n  = step_s;
    dwell_n = dwell_s;
    mode_n  = mode_s;
    if (abort) begin
      state_n = IDLE;
      busy_n  = 1'b0;
      dir_n   = 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        start_n = cfg_start_ftw;
        stop_n  = cfg_stop_ftw;
        step_n  = cfg_step_ftw;
        dwell_n = cfg_dwell;
        mode_n  = cfg_mode;
        ftw_n   = cfg_start_ftw;
        vld_n   = 1'b1;
        pclr_n  = 1'b1;
        cnt_n   = '0;
        dir_n   = 1'b0;
        if (cfg_step_ftw == '0 || cfg_start_ftw >= cfg_stop_ftw) done_n = 1'b1;
        else begin
          busy_n  = 1'b1;
          state_n = DWELL;
        end
      end
    end else if (cnt != dwell_m1) cnt_n = cnt + 1'b1;
    else begin
      cnt_n = '0;
      vld_n = 1'b1;
      if (!dir) begin
        if (ftw_out != stop_s) ftw_n = up_c;
        else if (mode_s == 2'd1) ftw_n = start_s;
        else if (mode_s == 2'd2) begin
          dir_n = 1'b1;
          ftw_n = dn_c;
        end else begin
          vld_n   = 1'b0;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end else if (ftw_out != start_s) ftw_n = dn_c;
      else begin
        dir_n = 1'b0;
        ftw_n = up_c;
      end
    end
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      dir       <= 1'b0;
      cnt       <= '0;
      ftw_out   <= '0;
      ftw_vld   <= 1'b0;
      phase_clr <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      start_s   <= '0;
      stop_s    <= '0;
      step_s    <= '0;
      dwell_s   <= '0;
      mode_s    <= '0;
    end else begin
      state     <= state_n;
      dir       <= dir_n;
      cnt       <= cnt_n;
      ftw_out   <= ftw_n;
      ftw_vld   <= vld_n;
      phase_clr <= pclr_n;
      busy      <= busy_n;
      done      <= done_n;
      start_s   <= start_n;
      stop_s    <= stop_n;
      step_s    <= step_n;
      dwell_s   <= dwell_n;
      mode_s    <= mode_n;
    end
  end
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: directed checks of ramp sequencing, clamping, abort, degenerate config and reset.
module tb_dds_sweep_ctrl;
  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [31:0] cfg_start_ftw = '0, cfg_stop_ftw = '0, cfg_step_ftw = '0;
  logic [23:0] cfg_dwell = '0;
  logic [1:0]  cfg_mode = '0;
  logic        start = 1'b0, abort = 1'b0;
  logic [31:0] ftw_out;
  logic        ftw_vld, phase_clr, busy, done;
  int tests = 0, fails = 0;
  int tri_seq[6] = '{0, 10, 20, 10, 0, 10};
  logic [31:0] saw_seq[3] = '{32'hFFFF_FFF0, 32'hFFFF_FFF8, 32'hFFFF_FFFF};

  dds_sweep_ctrl #(.FTW_W(32), .DWELL_W(24)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cfg_start_ftw(cfg_start_ftw), .cfg_stop_ftw(cfg_stop_ftw), .cfg_step_ftw(cfg_step_ftw),
    .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode), .start(start), .abort(abort),
    .ftw_out(ftw_out), .ftw_vld(ftw_vld), .phase_clr(phase_clr), .busy(busy), .done(done)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
    chk("done_busy_excl", {31'd0, done & busy}, 32'd0);
  endtask

  task automatic cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                     input logic [23:0] d, input logic [1:0] m);
    cfg_start_ftw = s;
    cfg_stop_ftw  = e;
    cfg_step_ftw  = st;
    cfg_dwell     = d;
    cfg_mode      = m;
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic ramp1(input bit disturb);
    cfg(100, 130, 10, 3, 0);
    kick();
    chk("r1_first_ftw", ftw_out, 100);
    chk("r1_first_vld", {31'd0, ftw_vld}, 1);
    chk("r1_first_pclr", {31'd0, phase_clr}, 1);
    chk("r1_first_busy", {31'd0, busy}, 1);
    for (int t = 1; t <= 12; t++) begin
      if (disturb && t == 4) begin
        start = 1'b1;
        cfg_stop_ftw = 200;
        cfg_start_ftw = 0;
      end
      if (disturb && t == 5) start = 1'b0;
      step();
      chk("r1_ftw", ftw_out, t >= 9 ? 130 : 100 + 10 * (t / 3));
      chk("r1_vld", {31'd0, ftw_vld}, (t % 3 == 0 && t < 12) ? 1 : 0);
      chk("r1_pclr", {31'd0, phase_clr}, 0);
      chk("r1_done", {31'd0, done}, t == 12 ? 1 : 0);
      chk("r1_busy", {31'd0, busy}, t < 12 ? 1 : 0);
    end
    step();
    chk("r1_done_one_shot", {31'd0, done}, 0);
  endtask

  initial begin
    step();
    step();
    chk("rst_ftw", ftw_out, 0);
    chk("rst_vld", {31'd0, ftw_vld}, 0);
    chk("rst_pclr", {31'd0, phase_clr}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    sys_rst = 1'b0;
    step();

    ramp1(1'b0);

    cfg(0, 25, 10, 0, 0);
    kick();
    chk("s2_ftw0", ftw_out, 0);
    step();
    chk("s2_ftw1", ftw_out, 10);
    step();
    chk("s2_ftw2", ftw_out, 20);
    step();
    chk("s2_ftw3_clamp", ftw_out, 25);
    chk("s2_vld3", {31'd0, ftw_vld}, 1);
    step();
    chk("s2_done", {31'd0, done}, 1);
    chk("s2_hold", ftw_out, 25);
    chk("s2_busy", {31'd0, busy}, 0);
    chk("s2_no_vld", {31'd0, ftw_vld}, 0);

    cfg(0, 20, 10, 2, 2);
    kick();
    chk("s3_ftw0", ftw_out, 0);
    for (int t = 1; t <= 10; t++) begin
      step();
      chk("s3_tri", ftw_out, tri_seq[t / 2]);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("s3_abort_busy", {31'd0, busy}, 0);
    chk("s3_abort_ftw", ftw_out, 10);
    chk("s3_abort_done", {31'd0, done}, 0);
    chk("s3_abort_vld", {31'd0, ftw_vld}, 0);
    for (int t = 0; t < 3; t++) begin
      step();
      chk("s3_idle_ftw", ftw_out, 10);
      chk("s3_idle_vld", {31'd0, ftw_vld}, 0);
      chk("s3_idle_done", {31'd0, done}, 0);
    end

    cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 8, 1, 1);
    kick();
    chk("s4_ftw0", ftw_out, 32'hFFFF_FFF0);
    chk("s4_pclr0", {31'd0, phase_clr}, 1);
    for (int t = 1; t <= 7; t++) begin
      step();
      chk("s4_saw", ftw_out, saw_seq[t % 3]);
      chk("s4_vld", {31'd0, ftw_vld}, 1);
      chk("s4_pclr", {31'd0, phase_clr}, 0);
      chk("s4_busy", {31'd0, busy}, 1);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("s4_abort_busy", {31'd0, busy}, 0);

    cfg(5, 9, 0, 3, 0);
    kick();
    chk("s5_deg_ftw", ftw_out, 5);
    chk("s5_deg_vld", {31'd0, ftw_vld}, 1);
    chk("s5_deg_pclr", {31'd0, phase_clr}, 1);
    chk("s5_deg_done", {31'd0, done}, 1);
    chk("s5_deg_busy", {31'd0, busy}, 0);
    step();
    chk("s5_deg_busy2", {31'd0, busy}, 0);
    chk("s5_deg_done2", {31'd0, done}, 0);

    cfg(50, 90, 10, 1, 0);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("s5_sa_vld", {31'd0, ftw_vld}, 0);
    chk("s5_sa_busy", {31'd0, busy}, 0);
    chk("s5_sa_ftw", ftw_out, 5);
    step();
    chk("s5_sa_busy2", {31'd0, busy}, 0);

    ramp1(1'b1);

    cfg(100, 130, 10, 3, 0);
    kick();
    for (int t = 1; t <= 4; t++) step();
    chk("s6_pre_ftw", ftw_out, 110);
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    chk("s6_rst_ftw", ftw_out, 0);
    chk("s6_rst_vld", {31'd0, ftw_vld}, 0);
    chk("s6_rst_pclr", {31'd0, phase_clr}, 0);
    chk("s6_rst_busy", {31'd0, busy}, 0);
    chk("s6_rst_done", {31'd0, done}, 0);
    step();
    step();
    chk("s6_idle_ftw", ftw_out, 0);
    chk("s6_idle_busy", {31'd0, busy}, 0);
    kick();
    chk("s6_restart_ftw", ftw_out, 100);
    chk("s6_restart_pclr", {31'd0, phase_clr}, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
